// File: rtl/input_viewer_overlay_ctrl.sv
// input_viewer_overlay_ctrl
// Maps VGA raster coordinates onto the shared sprite ROM address bus, waits out the
// 1-cycle ROM read latency, and composites d-pad fill overlays on top of the base image
// for buttons that are currently lit. Button state is sampled only on frame_start and
// held for HOLD_FRAMES further frames after release.
//
// Ports:
//   clk, reset        pixel clock, asynchronous active-high reset
//   x, y, video_on    raster position and active-video flag (stage 0)
//   frame_start       one-cycle pulse per frame; the only time lit/cnt update
//   buttons[3:0]      up, down, left, right levels
//   rom_row, rom_col  registered shared ROM address (stage 1)
//   base_data         base ROM output (stage 2)
//   fill_data[47:0]   four fill ROM outputs, fill i at [12i+11:12i] (stage 2)
//   pixel_out         registered RGB444 result (stage 3)
//   pixel_valid       video_on aligned with pixel_out
//   lit[3:0]          fill state currently applied to the composite
module input_viewer_overlay_ctrl #(
    parameter int unsigned IMG_W       = 584,
    parameter int unsigned IMG_H       = 167,
    parameter int unsigned X0          = 28,
    parameter int unsigned Y0          = 156,
    parameter logic [7:0]  HOLD_FRAMES = 8'd4,
    parameter logic [11:0] FILL_COLOR  = 12'hF80,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic [3:0]  buttons,
    output logic [7:0]  rom_row,
    output logic [9:0]  rom_col,
    input  logic [11:0] base_data,
    input  logic [47:0] fill_data,
    output logic [11:0] pixel_out,
    output logic        pixel_valid,
    output logic [3:0]  lit
);

    localparam logic [9:0] X_LO   = 10'(X0);
    localparam logic [9:0] X_HI   = 10'(X0 + IMG_W);
    localparam logic [9:0] Y_LO   = 10'(Y0);
    localparam logic [9:0] Y_HI   = 10'(Y0 + IMG_H);
    localparam logic [7:0] Y_LO_8 = 8'(Y0);

    // ---------------- stage 1: window test and address ----------------
    logic       in_win;
    logic [9:0] col_off;
    logic [7:0] row_off;

    assign in_win  = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
    assign col_off = x - X_LO;
    // Row fits in 8 bits on a hit, so the subtraction is done modulo 256 directly.
    assign row_off = y[7:0] - Y_LO_8;

    logic win_s1, von_s1;
    logic win_s2, von_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_row <= '0;
            rom_col <= '0;
            win_s1  <= 1'b0;
            von_s1  <= 1'b0;
            win_s2  <= 1'b0;
            von_s2  <= 1'b0;
        end else begin
            // Misses drive address 0 so an underflowed offset never reaches the bus.
            rom_row <= in_win ? row_off : '0;
            rom_col <= in_win ? col_off : '0;
            win_s1  <= in_win;
            von_s1  <= video_on;
            // Stage 2: flags ride alongside the ROM read.
            win_s2  <= win_s1;
            von_s2  <= von_s1;
        end
    end

    // ---------------- stage 3: composite ----------------
    logic        fill_hit;
    logic [11:0] pixel_d;

    always_comb begin
        fill_hit = 1'b0;
        // Every opaque lit fill yields FILL_COLOR, so the lowest-index winner
        // reduces to an OR across the fills.
        for (int i = 0; i < 4; i++) begin
            if (lit[i] && (fill_data[12*i +: 12] != 12'h000)) begin
                fill_hit = 1'b1;
            end
        end

        pixel_d = base_data;
        if (!von_s2) begin
            pixel_d = 12'h000;
        end else if (!win_s2) begin
            pixel_d = BG_COLOR;
        end else if (fill_hit) begin
            pixel_d = FILL_COLOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_out   <= pixel_d;
            pixel_valid <= von_s2;
        end
    end

    // ---------------- hold counters ----------------
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    logic [3:0] lit_d;

    always_comb begin
        lit_d = lit;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (frame_start) begin
            for (int i = 0; i < 4; i++) begin
                if (buttons[i]) begin
                    cnt_d[i] = HOLD_FRAMES;
                    lit_d[i] = 1'b1;
                end else if (cnt_q[i] != 8'd0) begin
                    cnt_d[i] = cnt_q[i] - 8'd1;
                    lit_d[i] = 1'b1;
                end else begin
                    lit_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lit <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            lit <= lit_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
